// File: rtl/tx_link_ctrl.sv
// tx_link_ctrl: symbol scheduler for the 8b/10b transmit path.
// Issues exactly one encoder/serializer load per SYM_PERIOD-clock slot.
// It sends a K28.5 alignment burst after reset, then idles on K28.5 and
// wraps source frames as SOF (K27.7), payload, fill (K23.7) and EOF (K29.7).
module tx_link_ctrl #(
  parameter int unsigned SYM_PERIOD = 11,
  parameter int unsigned N_ALIGN    = 16,
  parameter int unsigned MAX_LEN    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       enc_en,
  output logic       enc_kin,
  output logic [7:0] enc_din,
  output logic       link_up,
  output logic       busy,
  output logic       underrun,
  output logic       len_err
);

  localparam int unsigned CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam int unsigned AW = $clog2(N_ALIGN + 1);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SYM_PERIOD - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(N_ALIGN - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);

  localparam logic [1:0] ST_ALIGN = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_EOF   = 2'd3;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K29_7 = 8'hFD;

  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic [AW-1:0] align_cnt;
  logic [LW-1:0] byte_cnt;
  logic          decision;

  logic [1:0]    nxt_state;
  logic [AW-1:0] nxt_align;
  logic [LW-1:0] nxt_byte;
  logic [LW-1:0] byte_inc;
  logic          sym_k;
  logic [7:0]    sym_d;
  logic          nxt_busy;
  logic          nxt_link;
  logic          und_set;
  logic          len_set;

  assign decision = (cnt == CNT_LAST);
  assign byte_inc = byte_cnt + 1'b1;

  // Accept strobe: only in the decision cycle of a DATA slot.
  assign s_ready = decision && (state == ST_DATA);

  // Next symbol and next state, applied only on decision edges.
  always_comb begin
    nxt_state = state;
    nxt_align = align_cnt;
    nxt_byte  = byte_cnt;
    sym_k     = 1'b1;
    sym_d     = K28_5;
    nxt_busy  = busy;
    nxt_link  = link_up;
    und_set   = 1'b0;
    len_set   = 1'b0;
    case (state)
      ST_ALIGN: begin
        if (align_cnt == ALIGN_LAST) begin
          nxt_state = ST_IDLE;
          nxt_align = '0;
        end else begin
          nxt_align = align_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        // link_up and busy track the symbol being loaded, so they move
        // together with the enc_en of that symbol.
        nxt_link = 1'b1;
        nxt_busy = 1'b0;
        if (tx_enable && s_valid) begin
          sym_d     = K27_7;
          nxt_state = ST_DATA;
          nxt_busy  = 1'b1;
        end
      end
      ST_DATA: begin
        nxt_busy = 1'b1;
        if (s_valid) begin
          sym_k    = 1'b0;
          sym_d    = s_data;
          nxt_byte = byte_inc;
          if (s_last || (byte_inc == LEN_MAX)) begin
            nxt_state = ST_EOF;
          end
          if (!s_last && (byte_inc == LEN_MAX)) begin
            len_set = 1'b1;
          end
        end else begin
          sym_d   = K23_7;
          und_set = 1'b1;
        end
      end
      default: begin
        sym_d     = K29_7;
        nxt_byte  = '0;
        nxt_busy  = 1'b1;
        nxt_state = ST_IDLE;
      end
    endcase
  end

  // Slot counter, load strobe and all decision-edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      state     <= ST_ALIGN;
      align_cnt <= '0;
      byte_cnt  <= '0;
      enc_en    <= 1'b0;
      enc_kin   <= 1'b0;
      enc_din   <= '0;
      link_up   <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      cnt    <= decision ? '0 : cnt + 1'b1;
      enc_en <= decision;
      if (decision) begin
        state     <= nxt_state;
        align_cnt <= nxt_align;
        byte_cnt  <= nxt_byte;
        enc_kin   <= sym_k;
        enc_din   <= sym_d;
        link_up   <= nxt_link;
        busy      <= nxt_busy;
        underrun  <= underrun | und_set;
        len_err   <= len_err | len_set;
      end
    end
  end

endmodule
